vpu_mem_responder: RTL and testbench

VPU_MEM_RESPONDER -- requirements
Module: vpu_mem_responder

---
 rtl/vpu_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_vpu_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_mem_responder.sv
// vpu_mem_responder: operand/result memory sitting beside a VPU sequencer.
// On each start it fetches two operand words after a programmable read
// latency, presents them for one cycle, then waits for the VPU to hand back a
// result word, which it commits to the latched result address.
// A host port preloads the array while idle and reads it back at any time.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   start, addr_a/b/c           instruction issue strobe and its three addresses
//   data_c, vpu_done            result word and its strobe from the VPU
//   mem_rdy                     idle, start will be accepted
//   mem_read_en, data_a/b       operand words valid (one-cycle pulse)
//   mem_write_en                waiting for the result
//   xfer_done                   result committed (one-cycle pulse)
//   host_we/addr/wdata/rdata    host preload write and registered read
//   timeout_err                 watchdog pulse
//
// Optional feature: define VPU_MEM_TIMEOUT_EN to enable the EXEC watchdog.
// Without it the responder waits for vpu_done forever and timeout_err is 0.
module vpu_mem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] data_c,
  input  logic              vpu_done,
  output logic              mem_rdy,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              xfer_done,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              timeout_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, RD_WAIT, PRESENT, EXEC} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              xfer_q, xfer_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

`ifdef VPU_MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_err_q, tmo_err_d;
`endif

  // Next-state, datapath and array write-port selection
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    xfer_d       = 1'b0;
    host_rdata_d = mem_q[host_addr[IDX_W-1:0]];
    mem_we_c     = 1'b0;
    mem_waddr_c  = c_q;
    mem_wdata_c  = data_c;
`ifdef VPU_MEM_TIMEOUT_EN
    tmo_d        = tmo_q;
    tmo_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Host write lands on this edge, ahead of any operand read it races.
        if (host_we) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = host_addr[IDX_W-1:0];
          mem_wdata_c = host_wdata;
        end
        if (start) begin
          a_d     = addr_a[IDX_W-1:0];
          b_d     = addr_b[IDX_W-1:0];
          c_d     = addr_c[IDX_W-1:0];
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          data_a_d = mem_q[a_q];
          data_b_d = mem_q[b_q];
          state_d  = PRESENT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PRESENT: begin
        state_d = EXEC;
`ifdef VPU_MEM_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      EXEC: begin
        if (vpu_done) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = c_q;
          mem_wdata_c = data_c;
          xfer_d      = 1'b1;
          state_d     = IDLE;
        end
`ifdef VPU_MEM_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      host_rdata_q <= '0;
      xfer_q       <= 1'b0;
`ifdef VPU_MEM_TIMEOUT_EN
      tmo_q        <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      host_rdata_q <= host_rdata_d;
      xfer_q       <= xfer_d;
`ifdef VPU_MEM_TIMEOUT_EN
      tmo_q        <= tmo_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign mem_rdy      = (state_q == IDLE);
  assign mem_read_en  = (state_q == PRESENT);
  assign mem_write_en = (state_q == EXEC);
  assign data_a       = data_a_q;
  assign data_b       = data_b_q;
  assign host_rdata   = host_rdata_q;
  assign xfer_done    = xfer_q;

  // Upper address bits are deliberately dropped so addresses wrap.
  logic unused_c;
`ifdef VPU_MEM_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
  assign unused_c    = ^{addr_a, addr_b, addr_c, host_addr};
`else
  assign timeout_err = 1'b0;
  assign unused_c    = ^{addr_a, addr_b, addr_c, host_addr, 32'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_vpu_mem_responder.sv
// Directed bench for vpu_mem_responder with a transaction-level reference
// model compared against every output after every clock edge.
module tb_vpu_mem_responder;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
  logic [DATA_W-1:0] data_c;
  logic              vpu_done;
  logic              mem_rdy, mem_read_en, mem_write_en, xfer_done, timeout_err;
  logic [DATA_W-1:0] data_a, data_b;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;

  vpu_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .data_c(data_c), .vpu_done(vpu_done),
    .mem_rdy(mem_rdy), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .data_a(data_a), .data_b(data_b), .xfer_done(xfer_done),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] preload(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_known [DEPTH];
  bit                m_busy, m_exec, m_xfer, m_tmo, m_rknown;
  int                m_edge, m_rd_edge, m_exec_cyc;
  logic [7:0]        m_a, m_b, m_c;
  logic [DATA_W-1:0] m_da, m_db, m_rdata;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    m_edge = 0;
    forever begin
      @(posedge clk);
      #1;
      m_edge++;
      m_xfer = 1'b0;
      m_tmo  = 1'b0;
      if (!rst) begin
        m_busy = 1'b0; m_exec = 1'b0; m_da = '0; m_db = '0;
        m_rdata = '0; m_rknown = 1'b1; m_rd_edge = -10;
      end else begin
        m_rdata  = m_mem[host_addr[7:0]];
        m_rknown = m_known[host_addr[7:0]];
        if (!m_busy) begin
          if (host_we) begin
            m_mem[host_addr[7:0]]   = host_wdata;
            m_known[host_addr[7:0]] = 1'b1;
          end
          if (start) begin
            m_busy = 1'b1;
            m_a = addr_a[7:0]; m_b = addr_b[7:0]; m_c = addr_c[7:0];
            m_rd_edge = m_edge + int'(RD_LAT);
          end
        end else if (m_exec) begin
          if (vpu_done) begin
            m_mem[m_c]   = data_c;
            m_known[m_c] = 1'b1;
            m_xfer = 1'b1; m_busy = 1'b0; m_exec = 1'b0;
          end else begin
            m_exec_cyc++;
`ifdef VPU_MEM_TIMEOUT_EN
            if (m_exec_cyc == int'(TIMEOUT)) begin
              m_tmo = 1'b1; m_busy = 1'b0; m_exec = 1'b0;
            end
`endif
          end
        end else if (m_edge == m_rd_edge) begin
          m_da = m_mem[m_a];
          m_db = m_mem[m_b];
        end else if (m_edge == m_rd_edge + 1) begin
          m_exec = 1'b1;
          m_exec_cyc = 0;
        end
      end
      check("mem_rdy",      64'(mem_rdy),      64'(!m_busy));
      check("mem_read_en",  64'(mem_read_en),  64'(m_busy && !m_exec && m_edge == m_rd_edge));
      check("mem_write_en", 64'(mem_write_en), 64'(m_exec));
      check("data_a",       64'(data_a),       64'(m_da));
      check("data_b",       64'(data_b),       64'(m_db));
      check("xfer_done",    64'(xfer_done),    64'(m_xfer));
      check("timeout_err",  64'(timeout_err),  64'(m_tmo));
      if (m_rknown) check("host_rdata", 64'(host_rdata), 64'(m_rdata));
    end
  end

  // ---------------- stimulus helpers (entered at a falling edge) ----------------
  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] c);
    start = 1'b1; addr_a = a; addr_b = b; addr_c = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns with mem_read_en high; cyc counts falling edges since start was driven.
  task automatic wait_rd(output int cyc);
    cyc = 1;
    while (!mem_read_en && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rd_seen", 64'(mem_read_en), 64'(1));
  endtask

  task automatic done_pulse(input logic [DATA_W-1:0] d);
    vpu_done = 1'b1; data_c = d;
    @(negedge clk);
    vpu_done = 1'b0;
    check("xfer_pulse", 64'(xfer_done), 64'(1));
  endtask

  task automatic host_read(input string name, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] exp);
    host_addr = a;
    @(negedge clk);
    check(name, 64'(host_rdata), 64'(exp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int pulses;
    rst = 1'b0; start = 1'b0; vpu_done = 1'b0; host_we = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0; data_c = '0;
    host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_rdy",    64'(mem_rdy),      64'(1));
    check("rst_rd_en",      64'(mem_read_en),  64'(0));
    check("rst_wr_en",      64'(mem_write_en), 64'(0));
    check("rst_data_a",     64'(data_a),       64'(0));
    check("rst_host_rdata", 64'(host_rdata),   64'(0));
    rst = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) host_write(ADDR_W'(i), preload(i));

    // Basic transaction with RD_LAT=2
    host_write(16'd3, 32'h11);
    host_write(16'd7, 32'h22);
    issue(16'd3, 16'd7, 16'd9);
    wait_rd(cyc);
    check("t1_latency", 64'(cyc), 64'(3));
    check("t1_data_a", 64'(data_a), 64'h11);
    check("t1_data_b", 64'(data_b), 64'h22);
    @(negedge clk);
    check("t1_wr_en", 64'(mem_write_en), 64'(1));
    done_pulse(32'h33);
    host_read("t1_rd9", 16'd9, 32'h33);

    // Address wrap
    host_write(16'd5, 32'h55);
    issue(16'h0105, 16'h0005, 16'h0010);
    wait_rd(cyc);
    check("t2_data_a", 64'(data_a), 64'h55);
    check("t2_data_b", 64'(data_b), 64'h55);
    @(negedge clk);
    done_pulse(32'hAB);
    host_read("t2_wrap_rd", 16'h0310, 32'hAB);

    // Stray start and vpu_done while waiting on the read
    issue(16'd1, 16'd2, 16'd3);
    start = 1'b1; addr_a = 16'h40; addr_b = 16'h41; addr_c = 16'h42; vpu_done = 1'b1;
    @(negedge clk);
    start = 1'b0; vpu_done = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_read_en) pulses++;
      @(negedge clk);
    end
    check("t3_one_pulse", 64'(pulses), 64'(1));
    check("t3_data_a", 64'(data_a), 64'h5B5B_0101);
    check("t3_data_b", 64'(data_b), 64'h5858_0202);
    done_pulse(32'h00C0_FFEE);
    host_read("t3_rd40_untouched", 16'h40, preload(32'h40));

    // Host write and start together; host writes during EXEC are dropped
    host_we = 1'b1; host_addr = 16'd4; host_wdata = 32'hDEAD_BEEF;
    start = 1'b1; addr_a = 16'd4; addr_b = 16'd5; addr_c = 16'd6;
    @(negedge clk);
    host_we = 1'b0; start = 1'b0;
    wait_rd(cyc);
    check("t4_data_a_new", 64'(data_a), 64'hDEAD_BEEF);
    check("t4_data_b", 64'(data_b), 64'h55);
    @(negedge clk);
    host_write(16'd6, 32'h1234_5678);
    host_write(16'd5, 32'h99);
    done_pulse(32'h77);
    host_read("t4_rd5_unchanged", 16'd5, 32'h55);
    host_read("t4_rd6", 16'd6, 32'h77);

    // Result address equal to operand address reads the old value
    issue(16'd9, 16'd9, 16'd9);
    wait_rd(cyc);
    check("t5_old_value", 64'(data_a), 64'h33);
    @(negedge clk);
    done_pulse(32'h44);
    host_read("t5_rd9", 16'd9, 32'h44);

    // Reset in EXEC abandons the write
    issue(16'h20, 16'h21, 16'h22);
    wait_rd(cyc);
    @(negedge clk);
    check("t6_in_exec", 64'(mem_write_en), 64'(1));
    rst = 1'b0; vpu_done = 1'b1; data_c = 32'hBAD;
    #1;
    check("t6_rdy_now",   64'(mem_rdy),      64'(1));
    check("t6_wr_en_now", 64'(mem_write_en), 64'(0));
    check("t6_data_a_0",  64'(data_a),       64'(0));
    @(negedge clk);
    @(negedge clk);
    vpu_done = 1'b0; rst = 1'b1;
    host_read("t6_c_intact", 16'h22, 32'h7878_2222);
    host_read("t6_rd9_intact", 16'd9, 32'h44);

`ifdef VPU_MEM_TIMEOUT_EN
    issue(16'h30, 16'h31, 16'h32);
    wait_rd(cyc);
    cyc = 0;
    while (!timeout_err && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t7_tmo_cycles", 64'(cyc), 64'(9));
    check("t7_idle", 64'(mem_rdy), 64'(1));
    host_read("t7_c_intact", 16'h32, 32'h6868_3232);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
